// File: rtl/pixel_coord_source_if.sv
// pixel_coord_source_if: paired hcount/vcount AXI-Stream coordinate channels
interface pixel_coord_source_if;
  logic [10:0] hcount_axis_tdata;
  logic        hcount_axis_tvalid;
  logic        hcount_axis_tready;
  logic        hcount_axis_tlast;
  logic [9:0]  vcount_axis_tdata;
  logic        vcount_axis_tvalid;
  logic        vcount_axis_tready;
  modport master (
    output hcount_axis_tdata, hcount_axis_tvalid, hcount_axis_tlast,
    input  hcount_axis_tready,
    output vcount_axis_tdata, vcount_axis_tvalid,
    input  vcount_axis_tready
  );
  modport slave (
    input  hcount_axis_tdata, hcount_axis_tvalid, hcount_axis_tlast,
    output hcount_axis_tready,
    input  vcount_axis_tdata, vcount_axis_tvalid,
    output vcount_axis_tready
  );
endinterface

// File: rtl/pixel_coord_source.sv
// pixel_coord_source: raster-order pixel coordinates on two independent streams.
// PIXEL_SOURCE_CONTINUOUS_EN adds a stop input and free-running frames.
module pixel_coord_source #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,
`ifdef PIXEL_SOURCE_CONTINUOUS_EN
  input  logic stop,
`endif
  output logic busy,
  output logic frame_done,
  pixel_coord_source_if.master px
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic h_sent, v_sent, run, h_valid, v_valid, h_done, v_done;
  logic pix_done, h_last, v_last, frame_end, leave_run;
  assign run      = state == RUN;
  assign h_valid  = run & ~h_sent;
  assign v_valid  = run & ~v_sent;
  assign h_done   = h_sent | (h_valid & px.hcount_axis_tready);
  assign v_done   = v_sent | (v_valid & px.vcount_axis_tready);
  assign pix_done = run & h_done & v_done;
  assign h_last   = hcnt == 11'(H_ACTIVE - 1);
  assign v_last   = vcnt == 10'(V_ACTIVE - 1);
  assign frame_end = pix_done & h_last & v_last;
`ifdef PIXEL_SOURCE_CONTINUOUS_EN
  assign leave_run = stop;
`else
  assign leave_run = 1'b1;
`endif
  assign busy                  = run;
  assign px.hcount_axis_tdata  = hcnt;
  assign px.hcount_axis_tvalid = h_valid;
  assign px.hcount_axis_tlast  = run & h_last;
  assign px.vcount_axis_tdata  = vcnt;
  assign px.vcount_axis_tvalid = v_valid;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else          state <= state_d;
  // a start coinciding with the previous frame's done pulse is dropped
  always_comb begin
    state_d = state;
    if (state == IDLE)
      state_d = (start && !frame_done) ? RUN : IDLE;
    else if (frame_end && leave_run)
      state_d = IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      hcnt       <= '0;
      vcnt       <= '0;
      h_sent     <= 1'b0;
      v_sent     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (pix_done) begin
        h_sent <= 1'b0;
        v_sent <= 1'b0;
        hcnt   <= h_last ? '0 : hcnt + 11'd1;
        vcnt   <= h_last ? (v_last ? '0 : vcnt + 10'd1) : vcnt;
      end else if (run) begin
        h_sent <= h_done;
        v_sent <= v_done;
      end
    end
endmodule

// File: tb/tb_pixel_coord_source.sv
// tb_pixel_coord_source: directed checks of a 4x3 raster source.
module tb_pixel_coord_source;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b1;
  logic busy, frame_done;
  int n_chk = 0;
  int n_fail = 0;
  pixel_coord_source_if px ();
  pixel_coord_source #(.H_ACTIVE(4), .V_ACTIVE(3)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
`ifdef PIXEL_SOURCE_CONTINUOUS_EN
    .stop(stop),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .px(px.master)
  );
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_pix(input int i, input logic fd);
    check("hdata", 32'(px.hcount_axis_tdata), 32'(i % 4));
    check("vdata", 32'(px.vcount_axis_tdata), 32'(i / 4));
    check("hvalid", 32'(px.hcount_axis_tvalid), 1);
    check("vvalid", 32'(px.vcount_axis_tvalid), 1);
    check("tlast", 32'(px.hcount_axis_tlast), 32'(i % 4 == 3));
    check("busy", 32'(busy), 1);
    check("frame_done", 32'(frame_done), 32'(fd));
  endtask
  task automatic run_pix(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      check_pix(i, 1'b0);
      @(negedge aclk);
    end
  endtask
  task automatic end_frame();
    check("done_pulse", 32'(frame_done), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_hvalid", 32'(px.hcount_axis_tvalid), 0);
    check("idle_vvalid", 32'(px.vcount_axis_tvalid), 0);
    @(negedge aclk);
    check("done_once", 32'(frame_done), 0);
    check("still_idle", 32'(busy), 0);
  endtask
  task automatic kick();
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask
  initial begin
    px.hcount_axis_tready = 1'b1;
    px.vcount_axis_tready = 1'b1;
    @(negedge aclk);
    check("rst_busy", 32'(busy), 0);
    check("rst_hvalid", 32'(px.hcount_axis_tvalid), 0);
    check("rst_vvalid", 32'(px.vcount_axis_tvalid), 0);
    check("rst_tlast", 32'(px.hcount_axis_tlast), 0);
    check("rst_done", 32'(frame_done), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("pre_start_busy", 32'(busy), 0);
    kick();
    run_pix(0, 11);
    end_frame();
    kick();
    run_pix(0, 0);
    check_pix(1, 1'b0);
    px.vcount_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("stall_hvalid", 32'(px.hcount_axis_tvalid), 0);
      check("stall_vvalid", 32'(px.vcount_axis_tvalid), 1);
      check("stall_vdata", 32'(px.vcount_axis_tdata), 0);
      check("stall_hdata", 32'(px.hcount_axis_tdata), 1);
    end
    px.vcount_axis_tready = 1'b1;
    @(negedge aclk);
    run_pix(2, 11);
    end_frame();
    kick();
    run_pix(0, 5);
    px.hcount_axis_tready = 1'b0;
    px.vcount_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_pix(6, 1'b0);
      @(negedge aclk);
    end
    px.hcount_axis_tready = 1'b1;
    px.vcount_axis_tready = 1'b1;
    run_pix(6, 11);
    end_frame();
    kick();
    run_pix(0, 5);
    start = 1'b1;
    check_pix(6, 1'b0);
    @(negedge aclk);
    start = 1'b0;
    run_pix(7, 11);
    end_frame();
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("no_restart", 32'(busy), 0);
    end
    kick();
    run_pix(0, 4);
    check_pix(5, 1'b0);
    #1 aresetn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_hvalid", 32'(px.hcount_axis_tvalid), 0);
    check("arst_vvalid", 32'(px.vcount_axis_tvalid), 0);
    check("arst_hdata", 32'(px.hcount_axis_tdata), 0);
    check("arst_vdata", 32'(px.vcount_axis_tdata), 0);
    check("arst_tlast", 32'(px.hcount_axis_tlast), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_hvalid", 32'(px.hcount_axis_tvalid), 0);
    end
    kick();
    run_pix(0, 11);
    end_frame();
`ifdef PIXEL_SOURCE_CONTINUOUS_EN
    stop = 1'b0;
    kick();
    run_pix(0, 11);
    check_pix(0, 1'b1);
    @(negedge aclk);
    run_pix(1, 5);
    stop = 1'b1;
    run_pix(6, 11);
    end_frame();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_coord_source.md
PIXEL_COORD_SOURCE -- requirements
Module: pixel_coord_source

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, pixels per row (1..2047).
REQ-002 SHALL have parameter V_ACTIVE, default 720, rows per frame (1..1023).
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a frame.
REQ-006 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-007 SHALL have port frame_done, output, 1, a one-cycle pulse after the final pixel of a frame is accepted.
REQ-008 SHALL have port hcount_axis_tdata, output, 11, the column index of the current pixel.
REQ-009 SHALL have port hcount_axis_tvalid, output, 1; port hcount_axis_tready, input, 1.
REQ-010 SHALL have port hcount_axis_tlast, output, 1, high when hcount_axis_tdata == H_ACTIVE-1.
REQ-011 SHALL have port vcount_axis_tdata, output, 10, the row index of the current pixel.
REQ-012 SHALL have port vcount_axis_tvalid, output, 1; port vcount_axis_tready, input, 1.

Function
REQ-013 SHALL have states IDLE and RUN: IDLE to RUN on start; RUN to IDLE on acceptance of pixel (H_ACTIVE-1, V_ACTIVE-1); start is ignored in RUN.
REQ-014 SHALL drive busy = (state == RUN).
REQ-015 SHALL, on entering RUN, present pixel (0,0) on both streams in the cycle after start is sampled.
REQ-016 SHALL treat each stream independently: a stream transfer occurs when its tvalid and tready are both high on a clock edge.
REQ-017 SHALL hold each stream's tvalid high and its tdata stable until that stream's transfer occurs.
REQ-018 SHALL, after one stream transfers, deassert that stream's tvalid until the other stream has also transferred the same pixel (per-stream sent flag).
REQ-019 SHALL complete a pixel when both streams have transferred it, whether in the same cycle or in different cycles, and SHALL present the next pixel on both streams in the following cycle.
REQ-020 SHALL emit pixels in raster order: hcount 0..H_ACTIVE-1; then hcount wraps to 0 and vcount increments; vcount wraps to 0 after V_ACTIVE-1.
REQ-021 SHALL, with both treadys held high, sustain one pixel per cycle with no bubbles.
REQ-022 SHALL drive tvalid low on both streams in IDLE.
REQ-023 SHALL assert frame_done in the cycle after the final pixel completes, for exactly one cycle.
REQ-024 SHALL ignore tready inputs while in IDLE, and SHALL NOT accept a start that arrives in the same cycle as frame_done until IDLE is reached.

Reset
REQ-025 SHALL, while aresetn is low, force state = IDLE, both counters = 0, sent flags = 0, all tvalid = 0, tlast = 0, busy = 0, frame_done = 0, regardless of aclk.
REQ-026 SHALL abandon any frame in progress on reset, and SHALL require a new start after reset release; no partial pixel is resumed.

Configuration
REQ-027 SHALL support macro PIXEL_SOURCE_CONTINUOUS_EN.
REQ-028 SHALL, with PIXEL_SOURCE_CONTINUOUS_EN defined: wrap to (0,0) after the final pixel and remain in RUN; pulse frame_done at each frame boundary; return to IDLE only when input stop (1 bit, added only in this build) is high at a frame boundary.
REQ-029 SHALL, without PIXEL_SOURCE_CONTINUOUS_EN, generate exactly one frame per start, and SHALL NOT include the stop port.

Verification
REQ-030 SHALL cover: H_ACTIVE=4, V_ACTIVE=3, both treadys high, start pulse -> 12 pixels, one per cycle, (0,0)..(3,2); tlast on h=3; frame_done one cycle after (3,2); busy=0 afterwards.
REQ-031 SHALL cover: vcount_axis_tready low for 3 cycles at pixel (1,0) while hcount_axis_tready stays high -> hcount transfers once, hcount tvalid drops; vcount holds 0 with tvalid high; (2,0) appears the cycle after vcount transfers.
REQ-032 SHALL cover: both treadys low for 5 cycles mid-frame -> tdata and tvalid stable on both streams; no pixel skipped or duplicated.
REQ-033 SHALL cover: start asserted during RUN at pixel (2,1) -> no restart; the sequence continues to (3,2); a single frame_done.
REQ-034 SHALL cover: aresetn low at pixel (1,1) -> all outputs 0 asynchronously; after release, no activity until start; then the sequence restarts at (0,0).
REQ-035 SHALL cover: PIXEL_SOURCE_CONTINUOUS_EN build, stop high during the second frame -> frame_done pulses twice; the next pixel after (3,2) of frame 1 is (0,0); IDLE after frame 2.
